// File: rtl/adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adder                                                           |
// | Purpose  : Registered signed two-operand adder with carry/overflow flags,  |
// |            optional saturation and a configurable output pipeline.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module adder #(
  parameter int WIDTH    = 8,
  parameter int LATENCY  = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int              C_SW      = WIDTH + 2;
  localparam logic [WIDTH-1:0] C_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   w_raw;
  logic [WIDTH-1:0] w_wrap;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [C_SW-1:0]  w_stage;

  always_comb begin
    w_raw  = {1'b0, in1} + {1'b0, in2};
    w_wrap = w_raw[WIDTH-1:0];
    w_ovf  = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_wrap[WIDTH-1] != in1[WIDTH-1]);
    w_sum  = w_wrap;
    // On overflow both operands share a sign, so in1's sign picks the rail.
    if ((SATURATE != 0) && w_ovf) begin
      w_sum = in1[WIDTH-1] ? C_MIN_NEG : C_MAX_POS;
    end
    w_stage = {w_sum, w_raw[WIDTH], w_ovf};
  end

  // Stage 0 captures the arithmetic; later stages are pure delay.
  logic [C_SW-1:0] r_pipe [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_stage;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign {sum, carry, overflow} = r_pipe[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// Bench for adder: a wrapping LATENCY=1 instance and a saturating LATENCY=3
// instance, checked every cycle against an arithmetic model plus literal vectors.
module tb_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in1 = 8'h00;
  logic [7:0] in2 = 8'h00;
  logic [7:0] s1, s3;
  logic       c1, c3, o1, o3;

  int tests = 0;
  int fails = 0;

  adder #(.WIDTH(8), .LATENCY(1), .SATURATE(0)) u_wrap1 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2),
    .sum(s1), .carry(c1), .overflow(o1)
  );

  adder #(.WIDTH(8), .LATENCY(3), .SATURATE(1)) u_sat3 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2),
    .sum(s3), .carry(c3), .overflow(o3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got sum=%h carry=%b ovf=%b, expected sum=%h carry=%b ovf=%b",
               name, $time, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Plain integer arithmetic: signed range test for overflow, unsigned range for carry.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input bit sat);
    int          s;
    int          u;
    logic [31:0] sv;
    logic [7:0]  r;
    logic        ov;
    s  = int'($signed(a)) + int'($signed(b));
    u  = int'(a) + int'(b);
    sv = s;
    ov = (s > 127) || (s < -128);
    r  = sv[7:0];
    if (sat && ov) r = (s > 0) ? 8'h7F : 8'h80;
    return {r, (u > 255), ov};
  endfunction

  // Per-edge record of what was sampled; a reset wipes everything in flight.
  bit         hv [4096];
  logic [7:0] ha [4096];
  logic [7:0] hb [4096];
  int         ne = 0;

  always @(posedge clk) begin
    hv[ne] = !rst;
    ha[ne] = in1;
    hb[ne] = in2;
    ne++;
  end

  always @(posedge rst) begin
    for (int i = 0; i < ne; i++) hv[i] = 1'b0;
  end

  function automatic logic [9:0] exp_at(input int lat, input bit sat);
    int idx;
    idx = ne - lat;
    if (idx < 0) return '0;
    if (!hv[idx]) return '0;
    return model(ha[idx], hb[idx], sat);
  endfunction

  always @(negedge clk) begin
    chk("model_wrap1", {s1, c1, o1}, exp_at(1, 1'b0));
    chk("model_sat3",  {s3, c3, o3}, exp_at(3, 1'b1));
  end

  logic [7:0] va [6] = '{8'h03, 8'hFB, 8'hFF, 8'h80, 8'h7F, 8'h9C};
  logic [7:0] vb [6] = '{8'h04, 8'h02, 8'h01, 8'hFF, 8'h01, 8'h9C};
  logic [7:0] ew [6] = '{8'h07, 8'hFD, 8'h00, 8'h7F, 8'h80, 8'h38};
  logic [7:0] es [6] = '{8'h07, 8'hFD, 8'h00, 8'h80, 8'h7F, 8'h80};
  logic       ec [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
  logic       eo [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_wrap1", {s1, c1, o1}, 10'h000);
    chk("reset_sat3",  {s3, c3, o3}, 10'h000);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in1 = va[i];
      in2 = vb[i];
      repeat (3) @(negedge clk);
      chk("dir_wrap1", {s1, c1, o1}, {ew[i], ec[i], eo[i]});
      chk("dir_sat3",  {s3, c3, o3}, {es[i], ec[i], eo[i]});
    end

    // Outputs are nonzero here; reset must clear them before the next edge.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wrap1", {s1, c1, o1}, 10'h000);
    chk("async_rst_sat3",  {s3, c3, o3}, 10'h000);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      in1 = 8'($urandom);
      in2 = 8'($urandom);
      if (i == 500) begin
        #2 rst = 1'b1;
        #1;
        chk("midstream_rst_wrap1", {s1, c1, o1}, 10'h000);
        chk("midstream_rst_sat3",  {s3, c3, o3}, 10'h000);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    repeat (4) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
